// File: rtl/msrh_pkg.sv
// Shared sizing and state definitions for the ROB commit-stage controller.
package msrh_pkg;

    localparam int CMT_ENTRY_SIZE = 8;
    localparam int DISP_SIZE      = 4;
    localparam int CMT_BLK_W      = $clog2(CMT_ENTRY_SIZE) + 1;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } rob_ctrl_state_t;

endpackage

// File: rtl/msrh_rob_ptr.sv
// Circular ROB pointer: entry index in the low bits, wrap bit in the MSB.
module msrh_rob_ptr #(
    parameter int ENTRY_SIZE = msrh_pkg::CMT_ENTRY_SIZE
) (
    input  logic                        i_clk,
    input  logic                        i_reset_n,
    input  logic                        i_clear,
    input  logic                        i_inc,
    output logic [$clog2(ENTRY_SIZE):0] o_ptr
);

    localparam int W = $clog2(ENTRY_SIZE) + 1;

    logic [W-1:0] ptr_q;
    logic [W-1:0] ptr_d;

    // Depth is a power of two, so index overflow carries straight into the wrap bit.
    always_comb begin
        ptr_d = ptr_q;
        if (i_clear) begin
            ptr_d = '0;
        end else if (i_inc) begin
            ptr_d = ptr_q + W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign o_ptr = ptr_q;

endmodule

// File: rtl/msrh_rob_ctrl.sv
// ROB controller: allocates one block per dispatch group, retires the head block
// in order once it is all-done, and clears everything on flush.
module msrh_rob_ctrl #(
    parameter int CMT_ENTRY_SIZE = msrh_pkg::CMT_ENTRY_SIZE,
    parameter int DISP_SIZE      = msrh_pkg::DISP_SIZE
) (
    input  logic                                     i_clk,
    input  logic                                     i_reset_n,

    input  logic                                     i_disp_valid,
    output logic                                     o_disp_ready,
    output logic [$clog2(CMT_ENTRY_SIZE):0]          o_disp_cmt_id,
    output logic [CMT_ENTRY_SIZE-1:0]                o_entry_load,

    input  logic [CMT_ENTRY_SIZE-1:0]                i_entry_all_done,
    input  logic [CMT_ENTRY_SIZE-1:0][DISP_SIZE-1:0] i_entry_grp_id,
    output logic [CMT_ENTRY_SIZE-1:0]                o_entry_commit_finish,

    output logic                                     o_commit_valid,
    output logic [$clog2(CMT_ENTRY_SIZE):0]          o_commit_cmt_id,
    output logic [DISP_SIZE-1:0]                     o_commit_grp_id,

    input  logic                                     i_flush_valid,
    output logic                                     o_entry_flush,
    output logic [$clog2(CMT_ENTRY_SIZE):0]          o_rob_count
);

    import msrh_pkg::*;

    localparam int BLK_W = $clog2(CMT_ENTRY_SIZE) + 1;
    localparam int IDX_W = BLK_W - 1;

    rob_ctrl_state_t      state_q;
    rob_ctrl_state_t      state_d;
    logic [BLK_W-1:0]     head;
    logic [BLK_W-1:0]     tail;
    logic [BLK_W-1:0]     count_q;
    logic [BLK_W-1:0]     count_d;
    logic [IDX_W-1:0]     head_idx;
    logic [IDX_W-1:0]     tail_idx;
    logic                 in_run;
    logic                 full;
    logic                 empty;
    logic                 disp_fire;
    logic                 commit_fire;

    logic                 commit_valid_q;
    logic [BLK_W-1:0]     commit_cmt_id_q;
    logic [DISP_SIZE-1:0] commit_grp_id_q;

    assign head_idx = head[IDX_W-1:0];
    assign tail_idx = tail[IDX_W-1:0];
    assign in_run   = (state_q == RUN);
    assign full     = (count_q == BLK_W'(CMT_ENTRY_SIZE));
    assign empty    = (count_q == '0);

    // A flush in the same cycle suppresses both dispatch and commit.
    assign o_disp_ready = ~full & in_run & ~i_flush_valid;
    assign disp_fire    = i_disp_valid & o_disp_ready;
    assign commit_fire  = ~empty & i_entry_all_done[head_idx] & in_run & ~i_flush_valid;

    assign o_disp_cmt_id = tail;
    assign o_entry_flush = i_flush_valid | (state_q == FLUSH);
    assign o_rob_count   = count_q;

    always_comb begin
        o_entry_load          = '0;
        o_entry_commit_finish = '0;
        for (int unsigned i = 0; i < CMT_ENTRY_SIZE; i++) begin
            o_entry_load[i]          = disp_fire   && (tail_idx == IDX_W'(i));
            o_entry_commit_finish[i] = commit_fire && (head_idx == IDX_W'(i));
        end
    end

    msrh_rob_ptr #(.ENTRY_SIZE(CMT_ENTRY_SIZE)) u_tail_ptr (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_clear   (i_flush_valid),
        .i_inc     (disp_fire),
        .o_ptr     (tail)
    );

    msrh_rob_ptr #(.ENTRY_SIZE(CMT_ENTRY_SIZE)) u_head_ptr (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_clear   (i_flush_valid),
        .i_inc     (commit_fire),
        .o_ptr     (head)
    );

    // FLUSH lasts one cycle after the last flush request.
    always_comb begin
        state_d = i_flush_valid ? FLUSH : RUN;
        count_d = count_q;
        if (i_flush_valid) begin
            count_d = '0;
        end else if (disp_fire && !commit_fire) begin
            count_d = count_q + BLK_W'(1);
        end else if (commit_fire && !disp_fire) begin
            count_d = count_q - BLK_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q         <= RUN;
            count_q         <= '0;
            commit_valid_q  <= 1'b0;
            commit_cmt_id_q <= '0;
            commit_grp_id_q <= '0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            commit_valid_q <= commit_fire;
            if (commit_fire) begin
                commit_cmt_id_q <= head;
                commit_grp_id_q <= i_entry_grp_id[head_idx];
            end
        end
    end

    assign o_commit_valid  = commit_valid_q;
    assign o_commit_cmt_id = commit_cmt_id_q;
    assign o_commit_grp_id = commit_grp_id_q;

endmodule

// File: tb/tb_msrh_rob_ctrl.sv
// Directed and randomized bench for msrh_rob_ctrl against a pointer-arithmetic reference model.
module tb_msrh_rob_ctrl;
    import msrh_pkg::*;

    localparam int N = 8;
    localparam int D = DISP_SIZE;
    localparam int W = $clog2(N) + 1;

    logic                clk   = 1'b0;
    logic                rst_n = 1'b1;
    logic                disp_v = 1'b0;
    logic                flush  = 1'b0;
    logic [N-1:0]        done   = '0;
    logic [N-1:0][D-1:0] grp    = '0;

    logic                o_disp_ready;
    logic [W-1:0]        o_disp_cmt_id;
    logic [N-1:0]        o_entry_load;
    logic [N-1:0]        o_entry_commit_finish;
    logic                o_commit_valid;
    logic [W-1:0]        o_commit_cmt_id;
    logic [D-1:0]        o_commit_grp_id;
    logic                o_entry_flush;
    logic [W-1:0]        o_rob_count;

    int checks = 0;
    int errors = 0;

    // Reference model: pointers as plain integers modulo 2N, occupancy derived from them.
    int         m_head;
    int         m_tail;
    bit         m_in_flush;
    bit         m_cv;
    int         m_ccid;
    logic [D-1:0] m_cgrp;

    msrh_rob_ctrl #(.CMT_ENTRY_SIZE(N), .DISP_SIZE(D)) dut (
        .i_clk                 (clk),
        .i_reset_n             (rst_n),
        .i_disp_valid          (disp_v),
        .o_disp_ready          (o_disp_ready),
        .o_disp_cmt_id         (o_disp_cmt_id),
        .o_entry_load          (o_entry_load),
        .i_entry_all_done      (done),
        .i_entry_grp_id        (grp),
        .o_entry_commit_finish (o_entry_commit_finish),
        .o_commit_valid        (o_commit_valid),
        .o_commit_cmt_id       (o_commit_cmt_id),
        .o_commit_grp_id       (o_commit_grp_id),
        .i_flush_valid         (flush),
        .o_entry_flush         (o_entry_flush),
        .o_rob_count           (o_rob_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int m_count();
        return (m_tail - m_head + 2 * N) % (2 * N);
    endfunction

    // Called just after a rising edge with inputs already driven; checks, clocks, updates model.
    task automatic cycle();
        int           cnt;
        bit           rdy;
        bit           dfire;
        bit           cfire;
        logic [N-1:0] exp_load;
        logic [N-1:0] exp_fin;
        #1;
        cnt      = m_count();
        rdy      = (cnt < N) && !m_in_flush && !flush;
        dfire    = disp_v && rdy;
        cfire    = (cnt > 0) && done[m_head % N] && !m_in_flush && !flush;
        exp_load = '0;
        exp_fin  = '0;
        if (dfire) exp_load[m_tail % N] = 1'b1;
        if (cfire) exp_fin[m_head % N]  = 1'b1;
        chk("disp_ready",    o_disp_ready,          rdy);
        chk("entry_load",    o_entry_load,          exp_load);
        chk("commit_finish", o_entry_commit_finish, exp_fin);
        chk("entry_flush",   o_entry_flush,         flush || m_in_flush);
        chk("rob_count",     o_rob_count,           cnt);
        chk("disp_cmt_id",   o_disp_cmt_id,         m_tail);
        chk("commit_valid",  o_commit_valid,        m_cv);
        chk("commit_cmt_id", o_commit_cmt_id,       m_ccid);
        chk("commit_grp_id", o_commit_grp_id,       m_cgrp);
        @(posedge clk);
        m_cv = cfire;
        if (cfire) begin
            m_ccid = m_head;
            m_cgrp = grp[m_head % N];
        end
        if (flush) begin
            m_head     = 0;
            m_tail     = 0;
            m_in_flush = 1'b1;
        end else begin
            m_in_flush = 1'b0;
            if (dfire) m_tail = (m_tail + 1) % (2 * N);
            if (cfire) m_head = (m_head + 1) % (2 * N);
        end
        #1;
    endtask

    task automatic apply_reset();
        disp_v = 1'b0;
        flush  = 1'b0;
        done   = '0;
        rst_n  = 1'b0;
        #1;
        chk("rst_commit_valid",  o_commit_valid,        0);
        chk("rst_commit_cmt_id", o_commit_cmt_id,       0);
        chk("rst_commit_grp_id", o_commit_grp_id,       0);
        chk("rst_rob_count",     o_rob_count,           0);
        chk("rst_disp_ready",    o_disp_ready,          1);
        chk("rst_entry_flush",   o_entry_flush,         0);
        chk("rst_disp_cmt_id",   o_disp_cmt_id,         0);
        m_head     = 0;
        m_tail     = 0;
        m_in_flush = 1'b0;
        m_cv       = 1'b0;
        m_ccid     = 0;
        m_cgrp     = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < N; i++) grp[i] = D'(i + 3);
        apply_reset();
        cycle();

        // Fill the ROB back to back, then try one more.
        disp_v = 1'b1;
        repeat (8) cycle();
        chk("fill_count", o_rob_count, 8);
        chk("fill_ready", o_disp_ready, 0);
        cycle();

        // Only entry 0 done: exactly one retirement.
        disp_v = 1'b0;
        done   = 8'h01;
        cycle();
        chk("c0_valid", o_commit_valid, 1);
        chk("c0_cmt_id", o_commit_cmt_id, 0);
        cycle();
        chk("c0_pulse_end", o_commit_valid, 0);
        chk("c0_count", o_rob_count, 7);

        // Refill, then full with head done and dispatch valid together.
        done   = '0;
        disp_v = 1'b1;
        cycle();
        chk("refill_count", o_rob_count, 8);
        done = 8'h02;
        cycle();
        done = '0;
        cycle();
        chk("swap_count", o_rob_count, 8);
        chk("swap_cmt_id", o_commit_cmt_id, 1);

        // Flush while the head is done.
        apply_reset();
        disp_v = 1'b1;
        repeat (5) cycle();
        disp_v = 1'b0;
        done   = 8'h01;
        flush  = 1'b1;
        cycle();
        flush = 1'b0;
        chk("flush_state_out", o_entry_flush, 1);
        chk("flush_no_commit", o_commit_valid, 0);
        cycle();
        done = '0;
        chk("post_flush_count", o_rob_count, 0);
        chk("post_flush_id", o_disp_cmt_id, 0);
        disp_v = 1'b1;
        cycle();

        // Back-to-back flush requests stretch FLUSH.
        flush = 1'b1;
        repeat (2) cycle();
        flush = 1'b0;
        cycle();
        cycle();

        // Ten dispatches and ten commits, crossing the wrap bit.
        apply_reset();
        disp_v = 1'b1;
        repeat (8) cycle();
        disp_v = 1'b0;
        done   = '1;
        repeat (2) cycle();
        done   = '0;
        disp_v = 1'b1;
        cycle();
        chk("tenth_cmt_id", o_disp_cmt_id, 5'h09);
        cycle();
        disp_v = 1'b0;
        done   = '1;
        repeat (9) cycle();
        chk("drain_count", o_rob_count, 0);
        chk("drain_last_id", o_commit_cmt_id, 5'h09);

        // Reset with a commit pulse pending.
        done   = '0;
        disp_v = 1'b1;
        cycle();
        disp_v = 1'b0;
        done   = '1;
        cycle();
        chk("pend_valid", o_commit_valid, 1);
        apply_reset();
        cycle();

        // Randomized traffic.
        for (int n = 0; n < 500; n++) begin
            disp_v = 1'($urandom_range(0, 3) != 0);
            flush  = 1'($urandom_range(0, 19) == 0);
            done   = N'($urandom);
            for (int i = 0; i < N; i++) grp[i] = D'($urandom);
            if ($urandom_range(0, 149) == 0) begin
                apply_reset();
            end
            cycle();
        end
        disp_v = 1'b0;
        flush  = 1'b0;
        done   = '0;
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
